// File: rtl/alu_load_sequencer.sv
// Single-button load sequencer for a registered ALU datapath: debounces one pushbutton and
// steps the operand A / operand B / opcode / result load strobes, one stage per press.
module alu_load_sequencer #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int SETTLE_CYCLES   = 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_n,
   input  logic       abort,
   output logic       enA,
   output logic       enB,
   output logic       enO,
   output logic       enS,
   output logic [1:0] step,
   output logic       busy,
   output logic       result_valid
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES) + 1;
   localparam int SW = $clog2(SETTLE_CYCLES) + 1;
   localparam logic [DW-1:0] DB_TERM   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [SW-1:0] SETTLE_LD = SW'(SETTLE_CYCLES - 1);

   localparam logic [1:0] S_WAIT_A = 2'd0;
   localparam logic [1:0] S_WAIT_B = 2'd1;
   localparam logic [1:0] S_WAIT_O = 2'd2;
   localparam logic [1:0] S_SETTLE = 2'd3;

   logic [1:0]    btn_sync_q;
   logic [1:0]    abort_sync_q;
   logic          stable_q, stable_d;
   logic          stable_prev_q;
   logic          press_q;
   logic [DW-1:0] db_cnt_q, db_cnt_d;
   logic [1:0]    state_q, state_d;
   logic [SW-1:0] settle_q, settle_d;
   logic          ena_q, ena_d;
   logic          enb_q, enb_d;
   logic          eno_q, eno_d;
   logic          ens_q, ens_d;
   logic          busy_q, busy_d;
   logic          rv_q, rv_d;

   // Debounce: a new level is accepted only after it has persisted DEBOUNCE_CYCLES clocks
   always_comb begin
      stable_d = stable_q;
      db_cnt_d = db_cnt_q;
      if (btn_sync_q[1] == stable_q) begin
         db_cnt_d = {DW{1'b0}};
      end else if (db_cnt_q >= DB_TERM) begin
         stable_d = btn_sync_q[1];
         db_cnt_d = {DW{1'b0}};
      end else begin
         db_cnt_d = db_cnt_q + DW'(1);
      end
   end

   // Sequencer next state; abort overrides any press seen in the same cycle
   always_comb begin
      state_d  = state_q;
      settle_d = settle_q;
      ena_d    = 1'b0;
      enb_d    = 1'b0;
      eno_d    = 1'b0;
      ens_d    = 1'b0;
      rv_d     = rv_q;
      if (abort_sync_q[1]) begin
         state_d  = S_WAIT_A;
         settle_d = {SW{1'b0}};
         rv_d     = 1'b0;
      end else begin
         if (ens_q) begin
            rv_d = 1'b1;
         end else begin
            rv_d = rv_q;
         end
         case (state_q)
            S_WAIT_A: begin
               if (press_q) begin
                  ena_d   = 1'b1;
                  rv_d    = 1'b0;
                  state_d = S_WAIT_B;
               end else begin
                  state_d = S_WAIT_A;
               end
            end
            S_WAIT_B: begin
               if (press_q) begin
                  enb_d   = 1'b1;
                  state_d = S_WAIT_O;
               end else begin
                  state_d = S_WAIT_B;
               end
            end
            S_WAIT_O: begin
               if (press_q) begin
                  eno_d    = 1'b1;
                  settle_d = SETTLE_LD;
                  state_d  = S_SETTLE;
               end else begin
                  state_d = S_WAIT_O;
               end
            end
            S_SETTLE: begin
               // Presses arriving here are dropped on purpose, not queued
               if (settle_q == {SW{1'b0}}) begin
                  ens_d   = 1'b1;
                  state_d = S_WAIT_A;
               end else begin
                  settle_d = settle_q - SW'(1);
               end
            end
            default: begin
               state_d  = S_WAIT_A;
               settle_d = {SW{1'b0}};
            end
         endcase
      end
      busy_d = (state_d == S_SETTLE);
   end

   // Synchronizers, debounce state and press edge detector
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         btn_sync_q    <= 2'b11;
         abort_sync_q  <= 2'b00;
         stable_q      <= 1'b1;
         stable_prev_q <= 1'b1;
         press_q       <= 1'b0;
         db_cnt_q      <= {DW{1'b0}};
      end else begin
         btn_sync_q    <= {btn_sync_q[0], btn_n};
         abort_sync_q  <= {abort_sync_q[0], abort};
         stable_q      <= stable_d;
         stable_prev_q <= stable_q;
         press_q       <= stable_prev_q & ~stable_q;
         db_cnt_q      <= db_cnt_d;
      end
   end

   // Sequencer state and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_WAIT_A;
         settle_q <= {SW{1'b0}};
         ena_q    <= 1'b0;
         enb_q    <= 1'b0;
         eno_q    <= 1'b0;
         ens_q    <= 1'b0;
         busy_q   <= 1'b0;
         rv_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         settle_q <= settle_d;
         ena_q    <= ena_d;
         enb_q    <= enb_d;
         eno_q    <= eno_d;
         ens_q    <= ens_d;
         busy_q   <= busy_d;
         rv_q     <= rv_d;
      end
   end

   assign enA          = ena_q;
   assign enB          = enb_q;
   assign enO          = eno_q;
   assign enS          = ens_q;
   assign step         = state_q;
   assign busy         = busy_q;
   assign result_valid = rv_q;

endmodule

// File: tb/tb_alu_load_sequencer.sv
// Directed bench for alu_load_sequencer: DEBOUNCE_CYCLES=4; main instance SETTLE_CYCLES=2,
// second instance SETTLE_CYCLES=30 driven from its own button.
module tb_alu_load_sequencer;

   logic       clk;
   logic       rst_n;
   logic       btn_n, btn2_n, abort, abort2;
   logic       enA, enB, enO, enS, busy, result_valid;
   logic [1:0] step;
   logic       enA2, enB2, enO2, enS2, busy2, result_valid2;
   logic [1:0] step2;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   int cnt_a, cnt_b, cnt_o, cnt_s, multi;
   int ena_cyc, eno_cyc, ens_cyc;
   logic rv_at_ena, rv_at_ens, rv_after_ens, ens_prev, busy_at_eno;
   logic [1:0] step_at_eno;
   int cnt_a2, cnt_b2, cnt_o2, cnt_s2, busy2_cnt, eno2_cyc, ens2_cyc;

   alu_load_sequencer #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(2)) dut (
      .clk(clk), .rst_n(rst_n), .btn_n(btn_n), .abort(abort),
      .enA(enA), .enB(enB), .enO(enO), .enS(enS),
      .step(step), .busy(busy), .result_valid(result_valid)
   );

   alu_load_sequencer #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(30)) dut2 (
      .clk(clk), .rst_n(rst_n), .btn_n(btn2_n), .abort(abort2),
      .enA(enA2), .enB(enB2), .enO(enO2), .enS(enS2),
      .step(step2), .busy(busy2), .result_valid(result_valid2)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc++;

   // Strobe monitor, sampled on the inactive edge
   always @(negedge clk) begin
      if (enA) begin cnt_a++; ena_cyc = cyc; rv_at_ena = result_valid; end
      if (enB) cnt_b++;
      if (enO) begin cnt_o++; eno_cyc = cyc; step_at_eno = step; busy_at_eno = busy; end
      if (enS) begin cnt_s++; ens_cyc = cyc; rv_at_ens = result_valid; end
      if (ens_prev) rv_after_ens = result_valid;
      ens_prev = enS;
      if (int'(enA) + int'(enB) + int'(enO) + int'(enS) > 1) multi++;
      if (enA2) cnt_a2++;
      if (enB2) cnt_b2++;
      if (enO2) begin cnt_o2++; eno2_cyc = cyc; end
      if (enS2) begin cnt_s2++; ens2_cyc = cyc; end
      if (busy2) busy2_cnt++;
   end

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic clr();
      cnt_a = 0; cnt_b = 0; cnt_o = 0; cnt_s = 0;
      ena_cyc = -1; eno_cyc = -1; ens_cyc = -1;
      rv_at_ena = 1'bx; rv_at_ens = 1'bx; rv_after_ens = 1'bx;
      cnt_a2 = 0; cnt_b2 = 0; cnt_o2 = 0; cnt_s2 = 0; busy2_cnt = 0;
      eno2_cyc = -1; ens2_cyc = -100;
   endtask

   task automatic do_reset();
      @(posedge clk); #1 rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      clr();
   endtask

   task automatic press(input bit two, output int f);
      @(posedge clk); #1;
      if (two) btn2_n = 1'b0; else btn_n = 1'b0;
      f = cyc;
      repeat (12) @(posedge clk);
      #1;
      if (two) btn2_n = 1'b1; else btn_n = 1'b1;
      repeat (12) @(posedge clk);
      #1;
   endtask

   initial begin
      int f, rel;
      multi = 0;
      ens_prev = 1'b0;
      clr();
      // 1: reset with button held low
      rst_n = 1'b0; btn_n = 1'b0; btn2_n = 1'b1; abort = 1'b0; abort2 = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_strobes", int'({enA, enB, enO, enS}), 0);
      check("rst_step", int'(step), 0);
      check("rst_busy_rv", int'({busy, result_valid}), 0);
      @(posedge clk); #1 rst_n = 1'b1; rel = cyc;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("t1_ena_count", cnt_a, 1);
      check("t1_ena_latency", ena_cyc - rel, 8);
      check("t1_step", int'(step), 1);
      btn_n = 1'b1;
      repeat (12) @(posedge clk);

      // 2: clean press held 20 clocks
      do_reset();
      @(posedge clk); #1 btn_n = 1'b0; f = cyc;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("t2_ena_count", cnt_a, 1);
      check("t2_ena_latency", ena_cyc - f, 8);
      check("t2_no_enb_held", cnt_b, 0);
      check("t2_step", int'(step), 1);
      btn_n = 1'b1;
      repeat (12) @(posedge clk);

      // 3: bounce every 2 clocks, then settle low
      do_reset();
      @(posedge clk); #1;
      for (int i = 0; i < 6; i++) begin
         btn_n = i[0];
         repeat (2) @(posedge clk);
         #1;
      end
      check("t3_no_ena_bounce", cnt_a, 0);
      btn_n = 1'b0; f = cyc;
      repeat (20) @(posedge clk);
      @(negedge clk);
      check("t3_ena_count", cnt_a, 1);
      check("t3_ena_latency", ena_cyc - f, 8);
      btn_n = 1'b1;
      repeat (12) @(posedge clk);

      // 4: full sequence of four presses
      do_reset();
      press(1'b0, f);
      check("t4_p1_ena", cnt_a, 1);
      check("t4_p1_step", int'(step), 1);
      press(1'b0, f);
      check("t4_p2_enb", cnt_b, 1);
      check("t4_p2_step", int'(step), 2);
      press(1'b0, f);
      check("t4_p3_eno", cnt_o, 1);
      check("t4_ens_count", cnt_s, 1);
      check("t4_ens_gap", ens_cyc - eno_cyc, 2);
      check("t4_step_settle", int'(step_at_eno), 3);
      check("t4_busy_settle", int'(busy_at_eno), 1);
      check("t4_rv_at_ens", int'(rv_at_ens), 0);
      check("t4_rv_after_ens", int'(rv_after_ens), 1);
      check("t4_step_back", int'(step), 0);
      check("t4_rv_held", int'(result_valid), 1);
      press(1'b0, f);
      check("t4_p4_ena", cnt_a, 2);
      check("t4_rv_at_ena", int'(rv_at_ena), 0);
      check("t4_rv_cleared", int'(result_valid), 0);
      check("t4_p4_step", int'(step), 1);

      // 5: long settle, press during SETTLE dropped
      do_reset();
      press(1'b1, f);
      press(1'b1, f);
      press(1'b1, f);
      check("t5_eno_count", cnt_o2, 1);
      press(1'b1, f);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("t5_ens_gap", ens2_cyc - eno2_cyc, 30);
      check("t5_ens_count", cnt_s2, 1);
      check("t5_busy_cycles", busy2_cnt, 30);
      check("t5_no_extra_ena", cnt_a2, 1);
      check("t5_step", int'(step2), 0);

      // 6a: abort in WAIT_O
      do_reset();
      press(1'b0, f);
      press(1'b0, f);
      check("t6_step_wait_o", int'(step), 2);
      @(posedge clk); #1 abort = 1'b1;
      repeat (4) @(posedge clk);
      #1 abort = 1'b0;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("t6_abort_step", int'(step), 0);
      press(1'b0, f);
      check("t6_abort_ena", cnt_a, 2);
      check("t6_abort_ena_latency", ena_cyc - f, 8);
      check("t6_abort_no_eno", cnt_o, 0);
      check("t6_abort_step1", int'(step), 1);

      // 6b: reset during SETTLE suppresses enS
      press(1'b0, f);
      @(posedge clk); #1 btn_n = 1'b0; f = cyc;
      repeat (9) @(posedge clk);
      #1 rst_n = 1'b0; btn_n = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("t6_rst_eno_seen", eno_cyc - f, 8);
      check("t6_rst_no_ens", cnt_s, 0);
      check("t6_rst_step", int'(step), 0);
      check("t6_rst_busy_rv", int'({busy, result_valid}), 0);
      check("t6_rst_no_ena", cnt_a, 2);

      check("one_hot_strobes", multi, 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
